// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, two write ports and a per-register pending scoreboard.
// Latency: reads are zero-latency (optionally bypassed from same-cycle writes); writes and pending updates land on the next rising edge.
// Backpressure: none; every write and SetPending is accepted on the edge it is presented, except while ResetN is low.
module register_file_sb #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [ADDR_WIDTH-1:0] RS,
  input  logic [ADDR_WIDTH-1:0] RT,
  output logic [DATA_WIDTH-1:0] ReadRS,
  output logic [DATA_WIDTH-1:0] ReadRT,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] RD2,
  input  logic [DATA_WIDTH-1:0] WriteData2,
  input  logic                  RegWrite2,
  input  logic                  SetPending,
  input  logic [ADDR_WIDTH-1:0] PendAddr,
  output logic                  PendingRS,
  output logic                  PendingRT,
  output logic                  AnyPending
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Bit 0 is masked out of every write and scoreboard update when register 0 is hardwired.
  localparam logic [DEPTH-1:0] ZERO_MASK = (ZERO_REG != 0) ? DEPTH'(1) : '0;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pend;

  logic                  w_wr_a;
  logic                  w_wr_b;
  logic [DEPTH-1:0]      w_set_vec;
  logic [DEPTH-1:0]      w_clr_vec;
  logic [DATA_WIDTH-1:0] w_rs_dat;
  logic [DATA_WIDTH-1:0] w_rt_dat;

  // Qualify write enables: writes aimed at a hardwired zero register are dropped.
  always_comb begin
    w_wr_a = RegWrite;
    w_wr_b = RegWrite2;
    if (ZERO_REG != 0) begin
      if (RD == '0) begin
        w_wr_a = 1'b0;
      end
      if (RD2 == '0) begin
        w_wr_b = 1'b0;
      end
    end
  end

  // Decode scoreboard set/clear requests into one-hot vectors.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (SetPending) begin
      w_set_vec = DEPTH'(1) << PendAddr;
    end
    if (w_wr_a) begin
      w_clr_vec = w_clr_vec | (DEPTH'(1) << RD);
    end
    if (w_wr_b) begin
      w_clr_vec = w_clr_vec | (DEPTH'(1) << RD2);
    end
    w_set_vec = w_set_vec & ~ZERO_MASK;
    w_clr_vec = w_clr_vec & ~ZERO_MASK;
  end

  // Storage array: port B is written after port A so it wins a same-address collision.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr_a) begin
        r_regs[RD] <= WriteData;
      end
      if (w_wr_b) begin
        r_regs[RD2] <= WriteData2;
      end
    end
  end

  // Scoreboard: a new producer (set) outranks a completing write (clear) on the same register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_vec) | w_set_vec;
    end
  end

  // Read port RS: stored value, then bypass (B over A), then zero-register and reset overrides.
  always_comb begin
    w_rs_dat = r_regs[RS];
    if ((BYPASS != 0) && ResetN) begin
      if (RegWrite && (RD == RS)) begin
        w_rs_dat = WriteData;
      end
      if (RegWrite2 && (RD2 == RS)) begin
        w_rs_dat = WriteData2;
      end
    end
    if ((ZERO_REG != 0) && (RS == '0)) begin
      w_rs_dat = '0;
    end
    if (!ResetN) begin
      w_rs_dat = '0;
    end
  end

  // Read port RT: same priority chain as RS.
  always_comb begin
    w_rt_dat = r_regs[RT];
    if ((BYPASS != 0) && ResetN) begin
      if (RegWrite && (RD == RT)) begin
        w_rt_dat = WriteData;
      end
      if (RegWrite2 && (RD2 == RT)) begin
        w_rt_dat = WriteData2;
      end
    end
    if ((ZERO_REG != 0) && (RT == '0)) begin
      w_rt_dat = '0;
    end
    if (!ResetN) begin
      w_rt_dat = '0;
    end
  end

  assign ReadRS = w_rs_dat;
  assign ReadRT = w_rt_dat;

  // Pending flags come straight from stored bits; a same-cycle clear is not forwarded.
  assign PendingRS  = r_pend[RS] & ResetN;
  assign PendingRT  = r_pend[RT] & ResetN;
  assign AnyPending = (|r_pend) & ResetN;

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        Clock;
  logic        ResetN;
  logic [3:0]  RS, RT, RD, RD2, PendAddr;
  logic [23:0] WriteData, WriteData2;
  logic        RegWrite, RegWrite2, SetPending;

  logic [23:0] ReadRS, ReadRT, nb_ReadRS, nb_ReadRT;
  logic        PendingRS, PendingRT, AnyPending;
  logic        nb_PendingRS, nb_PendingRT, nb_AnyPending;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] exp_q [$];
  logic [23:0] e;

  register_file_sb #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .BYPASS(1), .ZERO_REG(1)) dut (
    .Clock(Clock), .ResetN(ResetN), .RS(RS), .RT(RT), .ReadRS(ReadRS), .ReadRT(ReadRT),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .RD2(RD2), .WriteData2(WriteData2), .RegWrite2(RegWrite2),
    .SetPending(SetPending), .PendAddr(PendAddr),
    .PendingRS(PendingRS), .PendingRT(PendingRT), .AnyPending(AnyPending)
  );

  register_file_sb #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .Clock(Clock), .ResetN(ResetN), .RS(RS), .RT(RT), .ReadRS(nb_ReadRS), .ReadRT(nb_ReadRT),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .RD2(RD2), .WriteData2(WriteData2), .RegWrite2(RegWrite2),
    .SetPending(SetPending), .PendAddr(PendAddr),
    .PendingRS(nb_PendingRS), .PendingRT(nb_PendingRT), .AnyPending(nb_AnyPending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; RegWrite2 = 1'b0; SetPending = 1'b0;
    RD = '0; RD2 = '0; PendAddr = '0; WriteData = '0; WriteData2 = '0;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    idle_inputs();
    RS = 4'd8; RT = 4'd9;
    #12;
    exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h0);
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL reset_rs: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRT !== e) begin n_err++; $display("FAIL reset_rt: got %h want %h", ReadRT, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL reset_any: got %b want %h", AnyPending, e); end
    ResetN = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    RD = 4'd8; WriteData = 24'd5; RegWrite = 1'b1;
    tick();
    RD = 4'd9; WriteData = 24'd7;
    tick();
    RegWrite = 1'b0;
    RS = 4'd8; RT = 4'd9;
    exp_q.push_back(24'd5); exp_q.push_back(24'd7);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL wr_rs8: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRT !== e) begin n_err++; $display("FAIL wr_rt9: got %h want %h", ReadRT, e); end
  endtask

  task automatic test_bypass();
    RD = 4'd3; WriteData = 24'hABCDEF; RegWrite = 1'b1; RS = 4'd3;
    exp_q.push_back(24'hABCDEF); exp_q.push_back(24'h0);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL byp_pre: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (nb_ReadRS !== e) begin n_err++; $display("FAIL nobyp_pre: got %h want %h", nb_ReadRS, e); end
    tick();
    RegWrite = 1'b0;
    exp_q.push_back(24'hABCDEF); exp_q.push_back(24'hABCDEF);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL byp_post: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (nb_ReadRS !== e) begin n_err++; $display("FAIL nobyp_post: got %h want %h", nb_ReadRS, e); end
  endtask

  task automatic test_dual_write();
    RD = 4'd5; WriteData = 24'd1; RegWrite = 1'b1;
    RD2 = 4'd5; WriteData2 = 24'd2; RegWrite2 = 1'b1;
    RS = 4'd5;
    exp_q.push_back(24'd2);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL dual_byp_prio: got %h want %h", ReadRS, e); end
    tick();
    RegWrite = 1'b0; RegWrite2 = 1'b0;
    exp_q.push_back(24'd2); exp_q.push_back(24'd2);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL dual_same: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (nb_ReadRS !== e) begin n_err++; $display("FAIL dual_same_nb: got %h want %h", nb_ReadRS, e); end
    RD = 4'd5; WriteData = 24'h10; RegWrite = 1'b1;
    RD2 = 4'd6; WriteData2 = 24'h11; RegWrite2 = 1'b1;
    tick();
    RegWrite = 1'b0; RegWrite2 = 1'b0;
    RS = 4'd5; RT = 4'd6;
    exp_q.push_back(24'h10); exp_q.push_back(24'h11);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL dual_diff_a: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRT !== e) begin n_err++; $display("FAIL dual_diff_b: got %h want %h", ReadRT, e); end
  endtask

  task automatic test_zero_reg();
    RD = 4'd0; WriteData = 24'hFFFFFF; RegWrite = 1'b1;
    SetPending = 1'b1; PendAddr = 4'd0; RS = 4'd0;
    exp_q.push_back(24'h0);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL zero_pre: got %h want %h", ReadRS, e); end
    tick();
    RegWrite = 1'b0; SetPending = 1'b0;
    exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h0);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL zero_post: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, PendingRS} !== e) begin n_err++; $display("FAIL zero_pend: got %b want %h", PendingRS, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL zero_any: got %b want %h", AnyPending, e); end
  endtask

  task automatic test_scoreboard();
    SetPending = 1'b1; PendAddr = 4'd4;
    tick();
    SetPending = 1'b0;
    RS = 4'd4; RT = 4'd5;
    exp_q.push_back(24'h1); exp_q.push_back(24'h0); exp_q.push_back(24'h1);
    #1;
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, PendingRS} !== e) begin n_err++; $display("FAIL sb_set_rs: got %b want %h", PendingRS, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, PendingRT} !== e) begin n_err++; $display("FAIL sb_set_rt5: got %b want %h", PendingRT, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL sb_set_any: got %b want %h", AnyPending, e); end
    RD2 = 4'd4; WriteData2 = 24'h44; RegWrite2 = 1'b1;
    exp_q.push_back(24'h1);
    #1;
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, PendingRS} !== e) begin n_err++; $display("FAIL sb_no_clr_byp: got %b want %h", PendingRS, e); end
    tick();
    RegWrite2 = 1'b0;
    exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h44);
    #1;
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, PendingRS} !== e) begin n_err++; $display("FAIL sb_clr_rs: got %b want %h", PendingRS, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL sb_clr_any: got %b want %h", AnyPending, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL sb_clr_data: got %h want %h", ReadRS, e); end
    SetPending = 1'b1; PendAddr = 4'd4;
    RD = 4'd4; WriteData = 24'h99; RegWrite = 1'b1;
    tick();
    SetPending = 1'b0; RegWrite = 1'b0;
    exp_q.push_back(24'h1); exp_q.push_back(24'h99);
    #1;
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, PendingRS} !== e) begin n_err++; $display("FAIL sb_set_wins: got %b want %h", PendingRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL sb_set_data: got %h want %h", ReadRS, e); end
  endtask

  task automatic test_mid_reset();
    RS = 4'd8; RT = 4'd9;
    exp_q.push_back(24'd5); exp_q.push_back(24'h1);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL pre_rst_rs8: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL pre_rst_any: got %b want %h", AnyPending, e); end
    ResetN = 1'b0;
    exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h0);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL rst_rs8: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRT !== e) begin n_err++; $display("FAIL rst_rt9: got %h want %h", ReadRT, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL rst_any: got %b want %h", AnyPending, e); end
    RD = 4'd8; WriteData = 24'h55; RegWrite = 1'b1;
    SetPending = 1'b1; PendAddr = 4'd9;
    exp_q.push_back(24'h0);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL rst_no_byp: got %h want %h", ReadRS, e); end
    tick();
    idle_inputs();
    #1;
    ResetN = 1'b1;
    tick();
    RS = 4'd8; RT = 4'd4;
    exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h0);
    #1;
    n_vec++; e = exp_q.pop_front();
    if (ReadRS !== e) begin n_err++; $display("FAIL post_rst_rs8: got %h want %h", ReadRS, e); end
    n_vec++; e = exp_q.pop_front();
    if (ReadRT !== e) begin n_err++; $display("FAIL post_rst_rt4: got %h want %h", ReadRT, e); end
    n_vec++; e = exp_q.pop_front();
    if ({23'b0, AnyPending} !== e) begin n_err++; $display("FAIL post_rst_any: got %b want %h", AnyPending, e); end
  endtask

  initial begin
    RS = '0; RT = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
